reg_file: RTL and testbench

//  Architectural register file with per-register rename tags (x0..x31). Sits beside the reorder buffer.
//  - Consumes the ROB's issue-pollution and commit streams.
//  - Gives the decoder/issue stage both source operands as a ready value or a ROB dependency tag.
//  - Unresolved tags are forwarded through the ROB query ports. Flush on clear_up drops all tags.

---
 rtl/reg_file_pkg.sv | 7 +
 rtl/reg_file_if.sv | 42 ++++
 rtl/reg_operand_lookup.sv | 41 ++++
 rtl/reg_file.sv | 83 ++++++++
 tb/tb_reg_file.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants for the architectural register file and its ROB link
package reg_file_pkg;
   localparam int ROB_BIT  = 4;
   localparam int ROB_SIZE = 1 << ROB_BIT;
   localparam int REG_BIT  = 5;
   localparam int REG_NUM  = 1 << REG_BIT;
endpackage

// File: rtl/reg_file_if.sv
// rtl/reg_file_if.sv - ROB issue/commit/query and decoder operand signals of the register file
interface reg_file_if;
   import reg_file_pkg::*;

   logic                issue_pollute;
   logic [REG_BIT-1:0]  issue_reg_id;
   logic [ROB_BIT-1:0]  issue_rob_entry;
   logic                rob_commit;
   logic [REG_BIT-1:0]  commit_rd_reg_id;
   logic [ROB_BIT-1:0]  commit_rob_entry;
   logic [31:0]         commit_value;
   logic [REG_BIT-1:0]  rs1_id;
   logic [REG_BIT-1:0]  rs2_id;
   logic [31:0]         rs1_val;
   logic [31:0]         rs2_val;
   logic                rs1_dep;
   logic                rs2_dep;
   logic [ROB_BIT-1:0]  rs1_tag;
   logic [ROB_BIT-1:0]  rs2_tag;
   logic [ROB_BIT-1:0]  get_rob_entry1;
   logic [ROB_BIT-1:0]  get_rob_entry2;
   logic                ready1;
   logic                ready2;
   logic [31:0]         value1;
   logic [31:0]         value2;

   modport master (
      output issue_pollute, issue_reg_id, issue_rob_entry,
      output rob_commit, commit_rd_reg_id, commit_rob_entry, commit_value,
      output rs1_id, rs2_id, ready1, ready2, value1, value2,
      input  rs1_val, rs2_val, rs1_dep, rs2_dep, rs1_tag, rs2_tag,
      input  get_rob_entry1, get_rob_entry2
   );

   modport slave (
      input  issue_pollute, issue_reg_id, issue_rob_entry,
      input  rob_commit, commit_rd_reg_id, commit_rob_entry, commit_value,
      input  rs1_id, rs2_id, ready1, ready2, value1, value2,
      output rs1_val, rs2_val, rs1_dep, rs2_dep, rs1_tag, rs2_tag,
      output get_rob_entry1, get_rob_entry2
   );
endinterface

// File: rtl/reg_operand_lookup.sv
// rtl/reg_operand_lookup.sv - resolves one source operand to a value or a pending ROB tag
module reg_operand_lookup
   import reg_file_pkg::*;
(
   input  logic [REG_BIT-1:0] i_src_id,
   input  logic [31:0]        i_src_val,
   input  logic               i_src_busy,
   input  logic [ROB_BIT-1:0] i_src_tag,
   input  logic               i_rob_commit,
   input  logic [REG_BIT-1:0] i_commit_rd_reg_id,
   input  logic [ROB_BIT-1:0] i_commit_rob_entry,
   input  logic [31:0]        i_commit_value,
   input  logic               i_ready,
   input  logic [31:0]        i_value,
   output logic [31:0]        o_val,
   output logic               o_dep,
   output logic [ROB_BIT-1:0] o_tag,
   output logic [ROB_BIT-1:0] o_get_rob_entry
);
   logic w_commit_hit;

   assign w_commit_hit    = i_rob_commit && (i_commit_rd_reg_id == i_src_id)
                            && (i_commit_rob_entry == i_src_tag);
   assign o_tag           = i_src_tag;
   assign o_get_rob_entry = i_src_tag;

   // Bypass order: settled register, then the producer retiring this cycle, then the ROB entry.
   always_comb begin
      o_val = '0;
      o_dep = 1'b0;
      if ((i_src_id == '0) || !i_src_busy) begin
         o_val = i_src_val;
      end else if (w_commit_hit) begin
         o_val = i_commit_value;
      end else if (i_ready) begin
         o_val = i_value;
      end else begin
         o_dep = 1'b1;
      end
   end
endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - architectural register file with per-register rename tags beside the ROB
module reg_file
   import reg_file_pkg::*;
(
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       rdy_in,
   input  logic       clear_up,
   reg_file_if.slave  bus
);
   logic [31:0]        r_val  [REG_NUM];
   logic               r_busy [REG_NUM];
   logic [ROB_BIT-1:0] r_tag  [REG_NUM];

   logic w_commit_en;
   logic w_issue_en;
   logic w_issue_same_rd;

   assign w_commit_en     = bus.rob_commit && (bus.commit_rd_reg_id != '0);
   assign w_issue_en      = bus.issue_pollute && (bus.issue_reg_id != '0) && !clear_up;
   assign w_issue_same_rd = w_issue_en && (bus.issue_reg_id == bus.commit_rd_reg_id);

   // A renaming issue to the same rd overrides the commit's busy clear and owns the tag.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_val[i]  <= '0;
            r_busy[i] <= 1'b0;
            r_tag[i]  <= '0;
         end
      end else if (rdy_in) begin
         if (clear_up) begin
            for (int i = 0; i < REG_NUM; i++) begin
               r_busy[i] <= 1'b0;
            end
         end
         if (w_commit_en) begin
            r_val[bus.commit_rd_reg_id] <= bus.commit_value;
            if ((r_tag[bus.commit_rd_reg_id] == bus.commit_rob_entry) && !w_issue_same_rd) begin
               r_busy[bus.commit_rd_reg_id] <= 1'b0;
            end
         end
         if (w_issue_en) begin
            r_busy[bus.issue_reg_id] <= 1'b1;
            r_tag[bus.issue_reg_id]  <= bus.issue_rob_entry;
         end
      end
   end

   reg_operand_lookup u_lookup_rs1 (
      .i_src_id           (bus.rs1_id),
      .i_src_val          (r_val[bus.rs1_id]),
      .i_src_busy         (r_busy[bus.rs1_id]),
      .i_src_tag          (r_tag[bus.rs1_id]),
      .i_rob_commit       (bus.rob_commit),
      .i_commit_rd_reg_id (bus.commit_rd_reg_id),
      .i_commit_rob_entry (bus.commit_rob_entry),
      .i_commit_value     (bus.commit_value),
      .i_ready            (bus.ready1),
      .i_value            (bus.value1),
      .o_val              (bus.rs1_val),
      .o_dep              (bus.rs1_dep),
      .o_tag              (bus.rs1_tag),
      .o_get_rob_entry    (bus.get_rob_entry1)
   );

   reg_operand_lookup u_lookup_rs2 (
      .i_src_id           (bus.rs2_id),
      .i_src_val          (r_val[bus.rs2_id]),
      .i_src_busy         (r_busy[bus.rs2_id]),
      .i_src_tag          (r_tag[bus.rs2_id]),
      .i_rob_commit       (bus.rob_commit),
      .i_commit_rd_reg_id (bus.commit_rd_reg_id),
      .i_commit_rob_entry (bus.commit_rob_entry),
      .i_commit_value     (bus.commit_value),
      .i_ready            (bus.ready2),
      .i_value            (bus.value2),
      .o_val              (bus.rs2_val),
      .o_dep              (bus.rs2_dep),
      .o_tag              (bus.rs2_tag),
      .o_get_rob_entry    (bus.get_rob_entry2)
   );
endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized and directed bench for reg_file against a behavioural model
module tb_reg_file;
   import reg_file_pkg::*;

   logic clk_in = 1'b0;
   logic rst_in;
   logic rdy_in;
   logic clear_up;

   reg_file_if bus ();

   reg_file dut (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .rdy_in   (rdy_in),
      .clear_up (clear_up),
      .bus      (bus)
   );

   always #5 clk_in = ~clk_in;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0]        m_val  [REG_NUM];
   bit                 m_busy [REG_NUM];
   logic [ROB_BIT-1:0] m_tag  [REG_NUM];

   task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic ref_lookup(input int s, input bit rdy_q, input logic [31:0] val_q,
                             output logic [31:0] val, output bit dep, output logic [ROB_BIT-1:0] tag);
      tag = m_tag[s];
      dep = 1'b0;
      val = '0;
      if (s == 0 || !m_busy[s])
         val = m_val[s];
      else if (bus.rob_commit && int'(bus.commit_rd_reg_id) == s && bus.commit_rob_entry == m_tag[s])
         val = bus.commit_value;
      else if (rdy_q)
         val = val_q;
      else
         dep = 1'b1;
   endtask

   task automatic check_outputs();
      logic [31:0] v;
      bit d;
      logic [ROB_BIT-1:0] t;
      ref_lookup(int'(bus.rs1_id), bus.ready1, bus.value1, v, d, t);
      check_eq("rs1_val", bus.rs1_val, v);
      check_eq("rs1_dep", bus.rs1_dep, d);
      check_eq("rs1_tag", bus.rs1_tag, t);
      check_eq("get_rob_entry1", bus.get_rob_entry1, t);
      ref_lookup(int'(bus.rs2_id), bus.ready2, bus.value2, v, d, t);
      check_eq("rs2_val", bus.rs2_val, v);
      check_eq("rs2_dep", bus.rs2_dep, d);
      check_eq("rs2_tag", bus.rs2_tag, t);
      check_eq("get_rob_entry2", bus.get_rob_entry2, t);
   endtask

   task automatic model_update();
      int cd;
      int id;
      cd = int'(bus.commit_rd_reg_id);
      id = int'(bus.issue_reg_id);
      if (rst_in) begin
         for (int i = 0; i < REG_NUM; i++) begin
            m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
         end
      end else if (rdy_in) begin
         bit issue_ok;
         bit release_rd;
         issue_ok   = bus.issue_pollute && id != 0 && !clear_up;
         release_rd = bus.rob_commit && cd != 0 && m_tag[cd] == bus.commit_rob_entry
                      && !(issue_ok && id == cd);
         if (clear_up)
            for (int i = 0; i < REG_NUM; i++) m_busy[i] = 1'b0;
         if (bus.rob_commit && cd != 0) m_val[cd] = bus.commit_value;
         if (release_rd) m_busy[cd] = 1'b0;
         if (issue_ok) begin
            m_busy[id] = 1'b1;
            m_tag[id]  = bus.issue_rob_entry;
         end
      end
   endtask

   task automatic settle();
      @(negedge clk_in);
      check_outputs();
   endtask

   task automatic tick();
      @(posedge clk_in);
      model_update();
      #1;
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   task automatic drive_idle();
      rdy_in = 1'b1; clear_up = 1'b0;
      bus.issue_pollute = 1'b0; bus.issue_reg_id = '0; bus.issue_rob_entry = '0;
      bus.rob_commit = 1'b0; bus.commit_rd_reg_id = '0; bus.commit_rob_entry = '0;
      bus.commit_value = '0;
      bus.ready1 = 1'b0; bus.ready2 = 1'b0; bus.value1 = '0; bus.value2 = '0;
   endtask

   task automatic pollute(input int rd, input int entry);
      bus.issue_pollute = 1'b1;
      bus.issue_reg_id = REG_BIT'(rd);
      bus.issue_rob_entry = ROB_BIT'(entry);
   endtask

   task automatic commit(input int rd, input int entry, input logic [31:0] value);
      bus.rob_commit = 1'b1;
      bus.commit_rd_reg_id = REG_BIT'(rd);
      bus.commit_rob_entry = ROB_BIT'(entry);
      bus.commit_value = value;
   endtask

   initial begin
      for (int i = 0; i < REG_NUM; i++) begin
         m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
      drive_idle();
      bus.rs1_id = '0; bus.rs2_id = '0;
      rst_in = 1'b1;
      tick(); tick();
      rst_in = 1'b0;

      // 1: reset state and an untagged commit
      bus.rs1_id = 5'd5; bus.rs2_id = 5'd31;
      settle();
      check_eq("t1_reset_val", bus.rs1_val, 32'h0);
      check_eq("t1_reset_dep", bus.rs1_dep, 1'b0);
      check_eq("t1_reset_get", bus.get_rob_entry2, 4'd0);
      tick();
      commit(5, 2, 32'h1234); step();
      drive_idle(); settle();
      check_eq("t1_commit_val", bus.rs1_val, 32'h1234);
      check_eq("t1_commit_dep", bus.rs1_dep, 1'b0);
      tick();

      // 2: pending operand, then forwarded from the ROB
      pollute(3, 4); step();
      drive_idle(); bus.rs1_id = 5'd3; settle();
      check_eq("t2_dep", bus.rs1_dep, 1'b1);
      check_eq("t2_tag", bus.rs1_tag, 4'd4);
      check_eq("t2_get", bus.get_rob_entry1, 4'd4);
      tick();
      bus.ready1 = 1'b1; bus.value1 = 32'hAB; settle();
      check_eq("t2_fwd_dep", bus.rs1_dep, 1'b0);
      check_eq("t2_fwd_val", bus.rs1_val, 32'hAB);
      tick();

      // 3: stale commit leaves the newer producer in place
      drive_idle();
      pollute(7, 1); step();
      pollute(7, 6); step();
      drive_idle(); commit(7, 1, 32'd9); step();
      drive_idle(); bus.rs1_id = 5'd7; settle();
      check_eq("t3_dep", bus.rs1_dep, 1'b1);
      check_eq("t3_tag", bus.rs1_tag, 4'd6);
      tick();

      // 4: commit and re-rename of the same register in one cycle
      pollute(8, 3); step();
      drive_idle(); commit(8, 3, 32'h55); pollute(8, 5); bus.rs1_id = 5'd8; settle();
      check_eq("t4_bypass_val", bus.rs1_val, 32'h55);
      check_eq("t4_bypass_dep", bus.rs1_dep, 1'b0);
      tick();
      drive_idle(); settle();
      check_eq("t4_dep", bus.rs1_dep, 1'b1);
      check_eq("t4_tag", bus.rs1_tag, 4'd5);
      tick();
      commit(8, 5, 32'h66); step();
      drive_idle(); settle();
      check_eq("t4_final_val", bus.rs1_val, 32'h66);
      tick();

      // 5: flush with same-cycle commit and discarded pollute
      for (int r = 1; r <= 4; r++) begin
         pollute(r, 9 + r); step();
      end
      drive_idle(); clear_up = 1'b1; commit(2, 0, 32'h77); pollute(9, 7); step();
      drive_idle();
      for (int r = 1; r <= 4; r++) begin
         bus.rs1_id = REG_BIT'(r); bus.rs2_id = 5'd9; settle();
         check_eq("t5_rs1_dep", bus.rs1_dep, 1'b0);
         check_eq("t5_x9_dep", bus.rs2_dep, 1'b0);
         if (r == 2) check_eq("t5_x2_val", bus.rs1_val, 32'h77);
         tick();
      end

      // 6: x0 is hardwired and rdy_in=0 freezes state
      pollute(0, 3); step();
      drive_idle(); commit(0, 0, 32'hFF); step();
      drive_idle(); bus.rs1_id = 5'd0; settle();
      check_eq("t6_x0_val", bus.rs1_val, 32'h0);
      check_eq("t6_x0_dep", bus.rs1_dep, 1'b0);
      tick();
      rdy_in = 1'b0; pollute(6, 2); step();
      drive_idle(); bus.rs1_id = 5'd6; settle();
      check_eq("t6_frozen_dep", bus.rs1_dep, 1'b0);
      tick();

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         rdy_in   = ($urandom_range(0, 9) != 0);
         clear_up = ($urandom_range(0, 19) == 0);
         bus.issue_pollute    = $urandom_range(0, 1);
         bus.issue_reg_id     = REG_BIT'($urandom_range(0, 11));
         bus.issue_rob_entry  = ROB_BIT'($urandom);
         bus.rob_commit       = $urandom_range(0, 1);
         bus.commit_rd_reg_id = REG_BIT'($urandom_range(0, 11));
         bus.commit_rob_entry = ($urandom_range(0, 1) != 0) ? m_tag[bus.commit_rd_reg_id]
                                                             : ROB_BIT'($urandom);
         bus.commit_value     = $urandom;
         bus.rs1_id = REG_BIT'($urandom_range(0, 11));
         bus.rs2_id = REG_BIT'($urandom_range(0, 11));
         bus.ready1 = ($urandom_range(0, 3) == 0);
         bus.ready2 = ($urandom_range(0, 3) == 0);
         bus.value1 = $urandom;
         bus.value2 = $urandom;
         if (c == 300) rst_in = 1'b1;
         step();
         rst_in = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
